// File: rtl/jk_reg_pkg.sv
// Shared mode codes, JK operation encodings and the JK next-state helper for jk_reg_array.
package jk_reg_pkg;

   localparam logic [1:0] JKM_JK    = 2'b00;
   localparam logic [1:0] JKM_UP    = 2'b01;
   localparam logic [1:0] JKM_SHIFT = 2'b10;
   localparam logic [1:0] JKM_DOWN  = 2'b11;

   // Encoded as {j, k}.
   typedef enum logic [1:0] {
      JkHold   = 2'b00,
      JkClear  = 2'b01,
      JkSet    = 2'b10,
      JkToggle = 2'b11
   } jk_op_e;

   function automatic logic jk_apply(input logic q, input logic j, input logic k);
      logic r;
      r = q;
      unique case (jk_op_e'({j, k}))
         JkHold:   r = q;
         JkClear:  r = 1'b0;
         JkSet:    r = 1'b1;
         JkToggle: r = ~q;
         default:  r = q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK storage bit: parallel load takes priority over the enabled JK update.
module jk_cell
   import jk_reg_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic load_i,
   input  logic d_i,
   input  logic j_i,
   input  logic k_i,
   output logic q_o
);

   logic q_d, q_q;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = d_i;
      end else if (en_i) begin
         q_d = jk_apply(q_q, j_i, k_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/jk_reg_array.sv
// Bank of JK cells usable as JK register, up/down counter or shift register.
// Optional per-bit change flags when JKREG_CHANGE_FLAG_EN is defined.
module jk_reg_array
   import jk_reg_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [1:0]       mode_i,
   input  logic [WIDTH-1:0] j_i,
   input  logic [WIDTH-1:0] k_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             sin_i,
   output logic [WIDTH-1:0] q_o,
   output logic             sout_o,
   output logic             co_o
`ifdef JKREG_CHANGE_FLAG_EN
   ,
   output logic [WIDTH-1:0] chg_o
`endif
);

   logic [WIDTH-1:0] j_eff, k_eff;
   logic [WIDTH-1:0] up_t, dn_t, shift_src;

   // Ripple toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      up_t    = '0;
      dn_t    = '0;
      up_t[0] = 1'b1;
      dn_t[0] = 1'b1;
      for (int unsigned i = 1; i < WIDTH; i++) begin
         up_t[i] = up_t[i-1] & q_o[i-1];
         dn_t[i] = dn_t[i-1] & ~q_o[i-1];
      end
   end

   assign shift_src = {q_o[WIDTH-2:0], sin_i};

   always_comb begin
      j_eff = j_i;
      k_eff = k_i;
      unique case (mode_i)
         JKM_JK: begin
            j_eff = j_i;
            k_eff = k_i;
         end
         JKM_UP: begin
            j_eff = up_t;
            k_eff = up_t;
         end
         JKM_SHIFT: begin
            j_eff = shift_src;
            k_eff = ~shift_src;
         end
         JKM_DOWN: begin
            j_eff = dn_t;
            k_eff = dn_t;
         end
         default: begin
            j_eff = j_i;
            k_eff = k_i;
         end
      endcase
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell #(
         .RESET_VAL (RESET_VAL[i])
      ) u_cell (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .en_i   (en_i),
         .load_i (load_i),
         .d_i    (d_i[i]),
         .j_i    (j_eff[i]),
         .k_i    (k_eff[i]),
         .q_o    (q_o[i])
      );
   end

   assign sout_o = q_o[WIDTH-1];
   assign co_o   = en_i & ~load_i &
                   (((mode_i == JKM_UP) & (&q_o)) | ((mode_i == JKM_DOWN) & ~(|q_o)));

`ifdef JKREG_CHANGE_FLAG_EN
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] chg_d, chg_q;

   // Mirrors the cell next-state so the flag lands in the cycle right after the change.
   always_comb begin
      q_nxt = q_o;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (load_i) begin
            q_nxt[i] = d_i[i];
         end else if (en_i) begin
            q_nxt[i] = jk_apply(q_o[i], j_eff[i], k_eff[i]);
         end
      end
      chg_d = q_nxt ^ q_o;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chg_q <= '0;
      end else begin
         chg_q <= chg_d;
      end
   end

   assign chg_o = chg_q;
`endif

endmodule

// File: tb/tb_jk_reg_array.sv
// Directed self-checking bench for jk_reg_array (WIDTH=8, RESET_VAL=8'hA5).
module tb_jk_reg_array;

   localparam int unsigned      W  = 8;
   localparam logic [W-1:0]     RV = 8'hA5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic [1:0]   mode;
   logic [W-1:0] j, k, d;
   logic         load, sin;
   logic [W-1:0] q;
   logic         sout, co;
`ifdef JKREG_CHANGE_FLAG_EN
   logic [W-1:0] chg;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   jk_reg_array #(
      .WIDTH     (W),
      .RESET_VAL (RV)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .en_i   (en),
      .mode_i (mode),
      .j_i    (j),
      .k_i    (k),
      .load_i (load),
      .d_i    (d),
      .sin_i  (sin),
      .q_o    (q),
      .sout_o (sout),
      .co_o   (co)
`ifdef JKREG_CHANGE_FLAG_EN
      ,
      .chg_o  (chg)
`endif
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = 2'b00; j = '0; k = '0;
      load = 1'b0; d = '0; sin = 1'b0;
      step();
      rst_n = 1'b1;
      load = 1'b1; d = 8'h12;
      step();
      chk("load_pre", q, 8'h12);
      load = 1'b0;

      // Async reset with no clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_q", q, RV);
      chk("rst_sout", {7'b0, sout}, 8'h01);
`ifdef JKREG_CHANGE_FLAG_EN
      chk("rst_chg", chg, 8'h00);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b0;
      step();
      chk("hold_en0", q, RV);

      // JK mode.
      load = 1'b1; d = 8'h0F;
      step();
      load = 1'b0;
      mode = 2'b00; j = 8'hF0; k = 8'h3C; en = 1'b1;
      #1;
      chk("co_jk", {7'b0, co}, 8'h00);
      step();
      chk("jk_rule", q, 8'hF3);

      // Count up wrap, then down wrap.
      mode = 2'b01; load = 1'b1; d = 8'hFE;
      step();
      load = 1'b0;
      #1;
      chk("co_up_fe", {7'b0, co}, 8'h00);
      step();
      chk("up_ff", q, 8'hFF);
      chk("co_up_ff", {7'b0, co}, 8'h01);
      step();
      chk("up_wrap", q, 8'h00);
      chk("co_up_00", {7'b0, co}, 8'h00);
      mode = 2'b11;
      #1;
      chk("co_dn_00", {7'b0, co}, 8'h01);
      step();
      chk("dn_wrap", q, 8'hFF);
      chk("co_dn_ff", {7'b0, co}, 8'h00);
      step();
      chk("dn_fe", q, 8'hFE);

      // Shift.
      mode = 2'b10; load = 1'b1; d = 8'h81;
      step();
      load = 1'b0; sin = 1'b1;
      #1;
      chk("co_shift", {7'b0, co}, 8'h00);
      step();
      chk("shift1", q, 8'h03);
      chk("sout_shift", {7'b0, sout}, 8'h00);
      sin = 1'b0;
      step();
      chk("shift2", q, 8'h06);

      // Load beats count.
      mode = 2'b01; en = 1'b1; load = 1'b1; d = 8'h30;
      #1;
      chk("co_load", {7'b0, co}, 8'h00);
      step();
      chk("load_30", q, 8'h30);
      d = 8'h3C;
      step();
      chk("load_3c", q, 8'h3C);
`ifdef JKREG_CHANGE_FLAG_EN
      chk("chg_0c", chg, 8'h0C);
`endif
      load = 1'b0; en = 1'b0;
      step();
      chk("hold_3c", q, 8'h3C);
`ifdef JKREG_CHANGE_FLAG_EN
      chk("chg_clr", chg, 8'h00);
`endif

      // Reset mid-count.
      load = 1'b1; d = 8'h45;
      step();
      load = 1'b0; en = 1'b1; mode = 2'b01;
      step();
      step();
      chk("cnt_47", q, 8'h47);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_midcnt", q, RV);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("cnt_restart", q, 8'hA6);
      mode = 2'b11;
      step();
      chk("dn_a5", q, 8'hA5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
